fifo_byte_serializer: RTL and testbench

//  Downstream consumer of the 24-bit show-ahead pixel FIFO. Pops one DW-bit word,

---
 rtl/fifo_byte_serializer.sv | 105 ++++++++++
 tb/tb_fifo_byte_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops DW-bit words from a show-ahead FIFO and streams them as OW-bit beats.
// Define FBS_LAST_EN to add the registered out_last end-of-word marker.
module fifo_byte_serializer #(
  parameter int DW        = 24,
  parameter int OW        = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic          clock,
  input  logic          sclr,
  input  logic          flush,
  input  logic [DW-1:0] fifo_q,
  input  logic          fifo_empty,
  output logic          fifo_rdreq,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef FBS_LAST_EN
  ,
  output logic          out_last
`endif
);

  localparam int NB = DW / OW;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          load;
  logic          at_last;

  // A new word is taken either from idle or as the final beat is accepted, so words abut.
  assign at_last    = (idx_q == LAST_IDX);
  assign load       = ~fifo_empty & ~flush &
                      ((state_q == IDLE) | ((state_q == SEND) & out_ready & at_last));
  assign fifo_rdreq = load & sclr;
  assign out_valid  = valid_q;
  assign out_data   = (MSB_FIRST != 0) ? shift_q[DW-1 -: OW] : shift_q[OW-1:0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (load) begin
      shift_d = fifo_q;
      idx_d   = '0;
      state_d = SEND;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: valid_d = 1'b0;
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              state_d = IDLE;
              valid_d = 1'b0;
            end else begin
              idx_d   = idx_q + 1'b1;
              shift_d = (MSB_FIRST != 0) ? (shift_q << OW) : (shift_q >> OW);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef FBS_LAST_EN
  logic last_q;

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      last_q <= 1'b0;
    end else begin
      last_q <= valid_d & (idx_d == LAST_IDX);
    end
  end

  assign out_last = last_q;
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: directed vector table, hand sequences and a randomized
// run against a queue-based model, on an MSB-first and an LSB-first instance in parallel.
module tb_fifo_byte_serializer;

  localparam int DW = 24;
  localparam int OW = 8;
  localparam int NB = DW / OW;

  logic          clock = 1'b0;
  logic          sclr;
  logic          flush;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic          out_ready;
  logic          rdreq_m, rdreq_l;
  logic          valid_m, valid_l;
  logic [OW-1:0] data_m, data_l;
`ifdef FBS_LAST_EN
  logic          last_m, last_l;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fifo_byte_serializer #(.DW(DW), .OW(OW), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .sclr(sclr), .flush(flush), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(rdreq_m), .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready)
`ifdef FBS_LAST_EN
    , .out_last(last_m)
`endif
  );

  fifo_byte_serializer #(.DW(DW), .OW(OW), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .sclr(sclr), .flush(flush), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(rdreq_l), .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready)
`ifdef FBS_LAST_EN
    , .out_last(last_l)
`endif
  );

  typedef struct {
    logic          empty;
    logic [DW-1:0] q;
    logic          ready;
    logic          rdreq;
    logic          valid;
    logic [OW-1:0] msb;
    logic [OW-1:0] lsb;
    logic          last;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] fifo_model[$];
  logic [OW-1:0] exp_msb[$];
  logic [OW-1:0] exp_lsb[$];

  task automatic addVec(input logic e, input logic [DW-1:0] q, input logic r, input logic rd,
                        input logic v, input logic [OW-1:0] m, input logic [OW-1:0] l,
                        input logic la);
    tbl.push_back('{e, q, r, rd, v, m, l, la});
  endtask

  task automatic applyStimulus(input logic e, input logic [DW-1:0] q, input logic r,
                               input logic f);
    fifo_empty = e;
    fifo_q     = q;
    out_ready  = r;
    flush      = f;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Both instances must agree on the pop/valid timing; they differ only in beat order.
  task automatic checkBoth(input string tag, input logic rd, input logic v, input logic chk_data,
                           input logic [OW-1:0] m, input logic [OW-1:0] l, input logic la);
    checkOutput({tag, " rdreq_msb"}, 32'(rdreq_m), 32'(rd));
    checkOutput({tag, " rdreq_lsb"}, 32'(rdreq_l), 32'(rd));
    checkOutput({tag, " valid_msb"}, 32'(valid_m), 32'(v));
    checkOutput({tag, " valid_lsb"}, 32'(valid_l), 32'(v));
    if (chk_data) begin
      checkOutput({tag, " data_msb"}, 32'(data_m), 32'(m));
      checkOutput({tag, " data_lsb"}, 32'(data_l), 32'(l));
    end
`ifdef FBS_LAST_EN
    checkOutput({tag, " last_msb"}, 32'(last_m), 32'(la));
    checkOutput({tag, " last_lsb"}, 32'(last_l), 32'(la));
`else
    if (la === 1'bx) $display("[TB] unreachable");
`endif
  endtask

  function automatic logic [OW-1:0] beatOf(input logic [DW-1:0] w, input int k, input bit msb);
    logic [DW-1:0] s;
    s = msb ? (w >> (DW - OW * (k + 1))) : (w >> (OW * k));
    return s[OW-1:0];
  endfunction

  // One clock of the reference model: a beat list per popped word, popped on acceptance.
  task automatic runCycle(input string tag, input bit rdy, input bit fl, input bit rst_pulse);
    logic          emp;
    logic          want_pop;
    logic          have;
    logic [DW-1:0] q;
    @(negedge clock);
    emp = (fifo_model.size() == 0);
    q   = emp ? DW'($urandom()) : fifo_model[0];
    applyStimulus(emp, q, rdy, fl);
    #1;
    have     = (exp_msb.size() != 0);
    want_pop = !emp && !fl && (!have || (rdy && exp_msb.size() == 1));
    checkBoth(tag, want_pop, have, have, have ? exp_msb[0] : '0, have ? exp_lsb[0] : '0,
              have && exp_msb.size() == 1);
    if (rst_pulse) begin
      #1 sclr = 1'b0;
      #1 checkBoth({tag, " async_rst"}, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
      exp_msb.delete();
      exp_lsb.delete();
      #1 sclr = 1'b1;
      want_pop = !emp && !fl;
    end
    if (fl) begin
      exp_msb.delete();
      exp_lsb.delete();
    end else begin
      if (exp_msb.size() != 0 && rdy) begin
        void'(exp_msb.pop_front());
        void'(exp_lsb.pop_front());
      end
      if (want_pop) begin
        for (int k = 0; k < NB; k++) begin
          exp_msb.push_back(beatOf(q, k, 1'b1));
          exp_lsb.push_back(beatOf(q, k, 1'b0));
        end
        void'(fifo_model.pop_front());
      end
    end
  endtask

  initial begin
    // Directed vectors: single word, two back-to-back words, backpressure with a word waiting.
    addVec(0, 24'hA1B2C3, 1, 1, 0, 8'h00, 8'h00, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hA1, 8'hC3, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hB2, 8'hB2, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hC3, 8'hA1, 1);
    addVec(0, 24'h112233, 1, 1, 0, 8'h00, 8'h00, 0);
    addVec(0, 24'h445566, 1, 0, 1, 8'h11, 8'h33, 0);
    addVec(0, 24'h445566, 1, 0, 1, 8'h22, 8'h22, 0);
    addVec(0, 24'h445566, 1, 1, 1, 8'h33, 8'h11, 1);
    addVec(1, 24'h000000, 1, 0, 1, 8'h44, 8'h66, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'h55, 8'h55, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'h66, 8'h44, 1);
    addVec(1, 24'h000000, 1, 0, 0, 8'h00, 8'h00, 0);
    addVec(0, 24'hA1B2C3, 1, 1, 0, 8'h00, 8'h00, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hA1, 8'hC3, 0);
    for (int i = 0; i < 5; i++) addVec(0, 24'hDDEEFF, 0, 0, 1, 8'hB2, 8'hB2, 0);
    addVec(0, 24'hDDEEFF, 1, 0, 1, 8'hB2, 8'hB2, 0);
    addVec(0, 24'hDDEEFF, 1, 1, 1, 8'hC3, 8'hA1, 1);
    addVec(1, 24'h000000, 1, 0, 1, 8'hDD, 8'hFF, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hEE, 8'hEE, 0);
    addVec(1, 24'h000000, 1, 0, 1, 8'hFF, 8'hDD, 1);
    addVec(1, 24'h000000, 1, 0, 0, 8'h00, 8'h00, 0);

    // Reset with a non-empty FIFO: no pop may be requested while sclr is low.
    sclr = 1'b0;
    applyStimulus(1'b0, 24'h5A5A5A, 1'b1, 1'b0);
    #12;
    checkBoth("reset", 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    @(negedge clock);
    fifo_empty = 1'b1;
    sclr = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      applyStimulus(tbl[i].empty, tbl[i].q, tbl[i].ready, 1'b0);
      #1;
      checkBoth($sformatf("row%0d", i), tbl[i].rdreq, tbl[i].valid, tbl[i].valid,
                tbl[i].msb, tbl[i].lsb, tbl[i].last);
    end

    // Long empty stretch: never pops, never valid.
    for (int i = 0; i < 20; i++) runCycle("empty", 1'b1, 1'b0, 1'b0);

    // Async reset at beat 1 of one word, then flush at beat 1 of a later word.
    fifo_model.push_back(24'hA1B2C3);
    fifo_model.push_back(24'h112233);
    fifo_model.push_back(24'hA1B2C3);
    fifo_model.push_back(24'h445566);
    runCycle("seq6", 1'b1, 1'b0, 1'b0);
    runCycle("seq6", 1'b1, 1'b0, 1'b0);
    runCycle("seq6_rst", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) runCycle("seq6", 1'b1, 1'b0, 1'b0);
    runCycle("seq6_flush", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) runCycle("seq6", 1'b1, 1'b0, 1'b0);

    // Randomized traffic, backpressure, flushes and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      bit rdy, fl, rs;
      if ($urandom_range(0, 99) < 40 && fifo_model.size() < 8)
        fifo_model.push_back(DW'($urandom()));
      rdy = ($urandom_range(0, 99) < 70);
      fl  = ($urandom_range(0, 99) < 3);
      rs  = ($urandom_range(0, 199) == 0);
      runCycle("rand", rdy, fl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
